seq_calculator: RTL and testbench
=================================

// Module: seq_calculator
// PURPOSE
//  Parametrised, registered successor of the 4-bit add/sub calculator.
//  - Ops: ADD, SUB and multi-cycle unsigned MUL on WIDTH-bit operands.
//  - Valid/ready handshake on both input and output.
//  - Status flags: carry, borrow, zero, err.
//  - Sits between an operand source (e.g. switch/UART front end) and a display or result sink.
// PARAMETERS
//  WIDTH   8   operand width in bits (>=2); result is 2*WIDTH bits
//  CNT_W   $clog2(WIDTH+1)   width of MUL step counter (derived, do not override)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        operand/op presented
//  in_ready   out  1        block can accept; high only in IDLE
//  a          in   WIDTH    operand A (unsigned)
//  b          in   WIDTH    operand B (unsigned)
//  op         in   2        00 ADD, 01 SUB, 10 MUL, 11 reserved
//  out_valid  out  1        result/flags valid; held until out_ready
//  out_ready  in   1        sink accepts result
//  result     out  2*WIDTH  result, zero-extended
//  carry      out  1        ADD carry-out (= result[WIDTH]); 0 for other ops
//  borrow     out  1        SUB: 1 iff a<b; 0 for other ops
//  zero       out  1        1 iff result==0 (0 when err)
//  err        out  1        reserved op code accepted
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, in_ready=1 after release, out_valid=0, result=0, all flags=0, counter=0, operand regs=0.
//  - Accept: in_valid&&in_ready at a rising edge; a, b, op latched there. Inputs are ignored while not IDLE.
//  - States:
//    - IDLE: ADD/SUB/11 -> DONE on the accept edge; MUL -> MUL_RUN.
//    - MUL_RUN: one shift-add step per edge, counter 0..WIDTH-1; after WIDTH step edges -> DONE.
//    - DONE: out_valid=1; outputs stable until out_valid&&out_ready at an edge -> IDLE.
//  - Latency: ADD/SUB/11 out_valid rises on the accept edge. MUL rises WIDTH edges after the accept edge.
//  - No accept in the same cycle as result handoff. in_ready=0 in MUL_RUN and DONE.
//  - ADD: result = {0.., cout, sum[WIDTH-1:0]} via ripple adder, cin=0. carry=cout.
//  - SUB: a + ~b + 1 on the same adder type (cin=1); result[WIDTH-1:0] = difference mod 2^WIDTH, upper bits 0.
//    - borrow = ~cout, so 5-9 gives borrow=1 and 9-9 gives borrow=0.
//  - MUL: radix-2 shift-add of unsigned a*b into a 2*WIDTH accumulator; exact product, no overflow possible.
//  - op 11: result=0, err=1, zero=0, carry=borrow=0.
//  - Flags are registered together with result and change only on entry to DONE or on reset.
//  - Reset mid-MUL: partial product is discarded; no out_valid is produced for that op.
//  - out_ready held high in DONE: handoff at the next edge; out_valid is high for exactly 1 cycle.
// STRUCTURE
//  - Package calc_pkg:
//    - typedef enum logic [1:0] op_e {OP_ADD, OP_SUB, OP_MUL, OP_RSVD}
//    - typedef enum logic [1:0] state_e {S_IDLE, S_MUL_RUN, S_DONE}
//  - Sub-module rca_adder #(WIDTH):
//    - Generate-built ripple-carry chain of full-adder cells; ports a, b, cin, sum, cout.
//    - One instance serves ADD and SUB (b muxed to ~b, cin=1 for SUB).
//  - The MUL accumulate step uses its own WIDTH+1-bit add inside seq_calculator. No other sub-modules.
// TESTING (WIDTH=8 unless noted)
//  1. ADD a=200,b=100 -> next edge out_valid=1, result=16'h012C, carry=1, zero=0.
//  2. SUB a=5,b=9 -> result=16'h00FC, borrow=1. SUB a=9,b=9 -> result=0, zero=1, borrow=0.
//  3. MUL a=255,b=255 -> result=16'hFE01, out_valid exactly 8 edges after accept.
//     - in_ready=0 throughout. Operand changes during run do not affect result.
//  4. Backpressure: ADD 3+4, out_ready=0 for 5 cycles -> result=7 held, out_valid=1, in_ready=0.
//     - out_ready=1 -> IDLE next edge.
//  5. Reset asserted 3 edges into MUL 13*11 (async, mid-cycle) -> all outputs 0 immediately, in_ready=1 after release.
//     - No out_valid for that op. A following ADD 1+1 yields 2.
//  6. op=11, a=1,b=1 -> out_valid next edge, err=1, result=0, zero=0. Repeat ADD/SUB/MUL checks at WIDTH=4 and WIDTH=16.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared op and state encodings for the sequential calculator.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_RSVD
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL_RUN,
        S_DONE
    } state_e;

endpackage

// File: rtl/rca_adder.sv
// Ripple-carry adder built from a generate chain of full-adder cells.
module rca_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[WIDTH];

endmodule

// File: rtl/seq_calculator.sv
// Registered ADD/SUB/MUL calculator with valid/ready on both sides.
module seq_calculator
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               carry,
    output logic               borrow,
    output logic               zero,
    output logic               err
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int RW    = 2 * WIDTH;

    state_e             r_state;
    state_e             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [RW-1:0]      r_prod;

    op_e                w_op;
    logic               w_accept;
    logic               w_handoff;
    logic               w_last;
    logic               w_is_sub;
    logic [WIDTH-1:0]   w_add_b;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [WIDTH:0]     w_mul_sum;
    logic [RW-1:0]      w_prod_next;

    assign w_op      = op_e'(op);
    assign w_accept  = in_valid && in_ready;
    assign w_handoff = out_valid && out_ready;
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

    // SUB reuses the adder as a + ~b + 1
    assign w_is_sub = (w_op == OP_SUB);
    assign w_add_b  = w_is_sub ? ~b : b;

    rca_adder #(.WIDTH(WIDTH)) u_rca (
        .a    (a),
        .b    (w_add_b),
        .cin  (w_is_sub),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Upper half accumulates, whole register shifts right each step
    assign w_mul_sum = {1'b0, r_prod[RW-1:WIDTH]}
                     + (r_prod[0] ? {1'b0, r_a} : '0);
    assign w_prod_next = {w_mul_sum, r_prod[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (w_op == OP_MUL) ? S_MUL_RUN : S_DONE;
                end
            end
            S_MUL_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_handoff) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_a    <= '0;
            r_prod <= '0;
            result <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
            zero   <= 1'b0;
            err    <= 1'b0;
        end else if (r_state == S_IDLE && w_accept) begin
            r_cnt  <= '0;
            r_a    <= a;
            r_prod <= {{WIDTH{1'b0}}, b};
            unique case (w_op)
                OP_ADD: begin
                    result <= {{(WIDTH-1){1'b0}}, w_cout, w_sum};
                    carry  <= w_cout;
                    borrow <= 1'b0;
                    zero   <= ~|{w_cout, w_sum};
                    err    <= 1'b0;
                end
                OP_SUB: begin
                    result <= {{WIDTH{1'b0}}, w_sum};
                    carry  <= 1'b0;
                    borrow <= ~w_cout;
                    zero   <= ~|w_sum;
                    err    <= 1'b0;
                end
                OP_RSVD: begin
                    result <= '0;
                    carry  <= 1'b0;
                    borrow <= 1'b0;
                    zero   <= 1'b0;
                    err    <= 1'b1;
                end
                OP_MUL: begin
                end
            endcase
        end else if (r_state == S_MUL_RUN) begin
            r_prod <= w_prod_next;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (w_last) begin
                result <= w_prod_next;
                carry  <= 1'b0;
                borrow <= 1'b0;
                zero   <= ~|w_prod_next;
                err    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_calculator.sv
// Scoreboard bench for seq_calculator at WIDTH 8, 4 and 16.
module tb_seq_calculator;
    import calc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic        iv8, ir8, ov8, or8, c8, bo8, z8, e8;
    logic [7:0]  a8, b8;
    logic [1:0]  op8;
    logic [15:0] res8;
    logic [19:0] q8[$];

    logic        iv4, ir4, ov4, or4, c4, bo4, z4, e4;
    logic [3:0]  a4, b4;
    logic [1:0]  op4;
    logic [7:0]  res4;
    logic [11:0] q4[$];

    logic        iv16, ir16, ov16, or16, c16, bo16, z16, e16;
    logic [15:0] a16, b16;
    logic [1:0]  op16;
    logic [31:0] res16;
    logic [35:0] q16[$];

    seq_calculator #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .op(op8),
        .out_valid(ov8), .out_ready(or8),
        .result(res8), .carry(c8), .borrow(bo8),
        .zero(z8), .err(e8)
    );

    seq_calculator #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .op(op4),
        .out_valid(ov4), .out_ready(or4),
        .result(res4), .carry(c4), .borrow(bo4),
        .zero(z4), .err(e4)
    );

    seq_calculator #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .op(op16),
        .out_valid(ov16), .out_ready(or16),
        .result(res16), .carry(c16), .borrow(bo16),
        .zero(z16), .err(e16)
    );

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic spurious(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: output with empty scoreboard", nm);
    endtask

    always @(negedge clk) begin
        if (!rst && ov8 && or8) begin
            if (q8.size() == 0) spurious("w8_out");
            else chk("w8_out", {c8, bo8, z8, e8, res8}, q8.pop_front());
        end
        if (!rst && ov4 && or4) begin
            if (q4.size() == 0) spurious("w4_out");
            else chk("w4_out", {c4, bo4, z4, e4, res4}, q4.pop_front());
        end
        if (!rst && ov16 && or16) begin
            if (q16.size() == 0) spurious("w16_out");
            else chk("w16_out", {c16, bo16, z16, e16, res16}, q16.pop_front());
        end
    end

    task automatic go8(input logic [1:0] o, input logic [7:0] x,
                       input logic [7:0] y, input logic push,
                       input logic [19:0] e);
        chk("w8_ready_idle", ir8, 1);
        if (push) q8.push_back(e);
        op8 = o; a8 = x; b8 = y; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    task automatic drain8();
        int n = 0;
        while (!ir8 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w8_back_to_idle", ir8, 1);
    endtask

    task automatic mulwait8(output int n);
        n = 0;
        while (!ov8 && n < 40) begin
            chk("w8_mul_busy", ir8, 0);
            a8 = 8'($urandom); b8 = 8'($urandom);
            op8 = 2'($urandom); iv8 = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        iv8 = 1'b0;
    endtask

    task automatic run4(input logic [1:0] o, input logic [3:0] x,
                        input logic [3:0] y, input logic [11:0] e);
        int n = 0;
        q4.push_back(e);
        op4 = o; a4 = x; b4 = y; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        while (!ir4 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w4_cycles", n, (o == OP_MUL) ? 5 : 1);
    endtask

    task automatic run16(input logic [1:0] o, input logic [15:0] x,
                         input logic [15:0] y, input logic [35:0] e);
        int n = 0;
        q16.push_back(e);
        op16 = o; a16 = x; b16 = y; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        while (!ir16 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w16_cycles", n, (o == OP_MUL) ? 17 : 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        iv8 = 0; or8 = 1; a8 = 0; b8 = 0; op8 = 0;
        iv4 = 0; or4 = 1; a4 = 0; b4 = 0; op4 = 0;
        iv16 = 0; or16 = 1; a16 = 0; b16 = 0; op16 = 0;
        #1 rst = 1'b1;
        #2;
        chk("rst_outputs", {ov8, c8, bo8, z8, e8, res8}, 21'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_in_ready", ir8, 1);

        go8(OP_ADD, 8'd200, 8'd100, 1, {4'b1000, 16'h012C});
        chk("add_latency", ov8, 1);
        @(posedge clk); #1;
        chk("add_one_cycle", ov8, 0);

        go8(OP_SUB, 8'd5, 8'd9, 1, {4'b0100, 16'h00FC});
        chk("sub_latency", ov8, 1);
        drain8();
        go8(OP_SUB, 8'd9, 8'd9, 1, {4'b0010, 16'h0000});
        drain8();

        go8(OP_MUL, 8'd255, 8'd255, 1, {4'b0000, 16'hFE01});
        mulwait8(n);
        chk("mul_latency", n, 8);
        drain8();
        go8(OP_MUL, 8'd0, 8'd200, 1, {4'b0010, 16'h0000});
        mulwait8(n);
        chk("mul0_latency", n, 8);
        drain8();

        or8 = 1'b0;
        go8(OP_ADD, 8'd3, 8'd4, 1, {4'b0000, 16'h0007});
        repeat (5) begin
            chk("bp_valid", ov8, 1);
            chk("bp_result", res8, 16'h0007);
            chk("bp_ready", ir8, 0);
            @(posedge clk); #1;
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", ov8, 0);
        chk("bp_release_ready", ir8, 1);

        go8(OP_MUL, 8'd13, 8'd11, 0, 20'h0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_outputs", {ov8, c8, bo8, z8, e8, res8}, 21'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ready", ir8, 1);
        n = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ov8) n++;
        end
        chk("midrst_no_out", n, 0);
        go8(OP_ADD, 8'd1, 8'd1, 1, {4'b0000, 16'h0002});
        drain8();

        go8(OP_RSVD, 8'd1, 8'd1, 1, {4'b0001, 16'h0000});
        chk("rsvd_latency", ov8, 1);
        chk("rsvd_err", e8, 1);
        drain8();

        run4(OP_ADD, 4'd9, 4'd8, {4'b1000, 8'h11});
        run4(OP_SUB, 4'd3, 4'd5, {4'b0100, 8'h0E});
        run4(OP_SUB, 4'd15, 4'd0, {4'b0000, 8'h0F});
        run4(OP_MUL, 4'd15, 4'd15, {4'b0000, 8'hE1});

        run16(OP_ADD, 16'hFFFF, 16'h0001, {4'b1000, 32'h0001_0000});
        run16(OP_SUB, 16'h1234, 16'h1234, {4'b0010, 32'h0000_0000});
        run16(OP_SUB, 16'h0000, 16'h0001, {4'b0100, 32'h0000_FFFF});
        run16(OP_MUL, 16'hFFFF, 16'hFFFF, {4'b0000, 32'hFFFE_0001});
        run16(OP_MUL, 16'd1234, 16'd5678, {4'b0000, 32'h006A_E9BC});

        @(posedge clk); #1;
        chk("q8_drained", q8.size(), 0);
        chk("q4_drained", q4.size(), 0);
        chk("q16_drained", q16.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
